// File: rtl/cpu_pkg.sv
// Shared control definitions for the multicycle MIPS core: sequencer state
// encoding, decoder stage codes and the latched decoder-flag record.
package cpu_pkg;

  // Width of the post-reset hold counter (RESET_PC_HOLD range 0..7)
  localparam int HOLD_W = 3;

  // Stage codes; the decoder emits these, the sequencer consumes them
  localparam logic [2:0] STG_ID_LAST  = 3'b000;
  localparam logic [2:0] STG_EX_LAST  = 3'b100;
  localparam logic [2:0] STG_NO_MEM   = 3'b101;
  localparam logic [2:0] STG_MEM_LAST = 3'b110;
  localparam logic [2:0] STG_FULL     = 3'b111;

  typedef enum logic [2:0] {
    S_WAIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } seq_state_t;

  // Decoder outputs captured when leaving ID. j and halt both finish in ID,
  // so their flags never have a later consumer and are not stored here.
  typedef struct packed {
    logic [2:0] stage;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
  } dec_lat_t;

  // Illegal codes 001/010/011 behave as ID-last
  function automatic logic [2:0] stage_norm(input logic [2:0] s);
    return s[2] ? s : STG_ID_LAST;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualified events; wraps naturally at 2^W
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multicycle MIPS core. Steps each instruction
// through IF/ID/EX/MEM/WB, gates datapath writes to the right phase and
// stops in S_HALT until reset.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycle_cnt / retire_cnt.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  stage,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jump,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        ir_write,
  output logic        pc_inc_write,
  output logic        pc_jump_write,
  output logic        pc_branch_write,
  output logic        rf_we,
  output logic        dm_we,
  output logic        instr_done,
  output logic        halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  localparam seq_state_t RST_STATE = (RESET_PC_HOLD == 0) ? S_IF : S_WAIT;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((RESET_PC_HOLD == 0) ? 0 : RESET_PC_HOLD - 1);

  seq_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  dec_lat_t          lat;
  logic [2:0]        stage_n;

  assign stage_n = stage_norm(stage);

  // Phase FSM; decoder flags are captured on the edge leaving ID
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      hold_cnt <= '0;
      lat      <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (hold_cnt == HOLD_LAST) state <= S_IF;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end
        S_IF: state <= S_ID;
        S_ID: begin
          lat <= {stage_n, reg_write, mem_write, branch};
          if (halt)                        state <= S_HALT;
          else if (stage_n == STG_ID_LAST) state <= S_IF;
          else                             state <= S_EX;
        end
        S_EX: begin
          case (lat.stage)
            STG_NO_MEM:             state <= S_WB;
            STG_MEM_LAST, STG_FULL: state <= S_MEM;
            default:                state <= S_IF;
          endcase
        end
        S_MEM: begin
          // hold here until the data memory accepts the access
          if (mem_ready) state <= (lat.stage == STG_FULL) ? S_WB : S_IF;
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  assign if_en  = (state == S_IF);
  assign id_en  = (state == S_ID);
  assign ex_en  = (state == S_EX);
  assign mem_en = (state == S_MEM);
  assign wb_en  = (state == S_WB);
  assign halted = (state == S_HALT);

  assign ir_write        = if_en;
  assign pc_inc_write    = if_en;
  // jump resolves in ID, before any flag is latched
  assign pc_jump_write   = id_en & jump & ~halt;
  assign pc_branch_write = ex_en & lat.branch & branch_taken;
  assign rf_we           = wb_en & lat.reg_write;
  assign dm_we           = mem_en & lat.mem_write & mem_ready;

  // ID-last instructions end before latching, so that term uses live inputs
  assign instr_done = (id_en & ~halt & (stage_n == STG_ID_LAST))
                    | (ex_en & (lat.stage == STG_EX_LAST))
                    | (mem_en & mem_ready & (lat.stage == STG_MEM_LAST))
                    | wb_en;

`ifdef SEQ_PERF_CNT_EN
  perf_counter #(.W(32)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state != S_HALT),
    .count (cycle_cnt)
  );

  perf_counter #(.W(32)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_done),
    .count (retire_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: one table of per-cycle vectors
// plus hand sequences for halt, reset recovery and the reset hold.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] stage;
  logic       reg_write, mem_write, branch, jump, halt;
  logic       branch_taken, mem_ready;

  logic if_en, id_en, ex_en, mem_en, wb_en, ir_write, pc_inc_write;
  logic pc_jump_write, pc_branch_write, rf_we, dm_we, instr_done, halted;
  logic h_if, h_id, h_ex, h_mem, h_wb, h_ir, h_pci, h_pcj, h_pcb;
  logic h_rf, h_dm, h_done, h_halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, retire_cnt, h_cyc, h_ret;
`endif

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .stage(stage), .reg_write(reg_write),
    .mem_write(mem_write), .branch(branch), .jump(jump), .halt(halt),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .ir_write(ir_write), .pc_inc_write(pc_inc_write),
    .pc_jump_write(pc_jump_write), .pc_branch_write(pc_branch_write),
    .rf_we(rf_we), .dm_we(dm_we), .instr_done(instr_done), .halted(halted)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  // Second instance exercising the post-reset hold
  multicycle_sequencer #(.RESET_PC_HOLD(2)) dut_h (
    .clk(clk), .rst(rst), .stage(stage), .reg_write(reg_write),
    .mem_write(mem_write), .branch(branch), .jump(jump), .halt(halt),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .if_en(h_if), .id_en(h_id), .ex_en(h_ex), .mem_en(h_mem), .wb_en(h_wb),
    .ir_write(h_ir), .pc_inc_write(h_pci),
    .pc_jump_write(h_pcj), .pc_branch_write(h_pcb),
    .rf_we(h_rf), .dm_we(h_dm), .instr_done(h_done), .halted(h_halted)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(h_cyc), .retire_cnt(h_ret)
`endif
  );

  logic [12:0] obs, obs_h;
  assign obs   = {if_en, id_en, ex_en, mem_en, wb_en, ir_write, pc_inc_write,
                  pc_jump_write, pc_branch_write, rf_we, dm_we, instr_done, halted};
  assign obs_h = {h_if, h_id, h_ex, h_mem, h_wb, h_ir, h_pci,
                  h_pcj, h_pcb, h_rf, h_dm, h_done, h_halted};

  // Expected-output building blocks
  localparam logic [12:0] P_IF   = 13'h10C0; // if_en + ir_write + pc_inc_write
  localparam logic [12:0] P_ID   = 13'h0800;
  localparam logic [12:0] P_EX   = 13'h0400;
  localparam logic [12:0] P_MEM  = 13'h0200;
  localparam logic [12:0] P_WB   = 13'h0100;
  localparam logic [12:0] B_PCJ  = 13'h0020;
  localparam logic [12:0] B_PCB  = 13'h0010;
  localparam logic [12:0] B_RF   = 13'h0008;
  localparam logic [12:0] B_DM   = 13'h0004;
  localparam logic [12:0] B_DONE = 13'h0002;
  localparam logic [12:0] B_HALT = 13'h0001;

  // Decoder flag packing {reg_write, mem_write, branch, jump, halt}
  localparam logic [4:0] F_0  = 5'b00000;
  localparam logic [4:0] F_RW = 5'b10000;
  localparam logic [4:0] F_MW = 5'b01000;
  localparam logic [4:0] F_BR = 5'b00100;
  localparam logic [4:0] F_JP = 5'b00010;
  localparam logic [4:0] F_HT = 5'b00001;

  typedef struct {
    logic [2:0]  stg;
    logic [4:0]  flg;
    logic        bt;
    logic        mr;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [2:0] s, input logic [4:0] f,
                              input logic b, input logic m, input logic [12:0] e);
    vec_t v;
    v.stg = s; v.flg = f; v.bt = b; v.mr = m; v.exp = e;
    return v;
  endfunction

  task automatic apply(input logic [2:0] s, input logic [4:0] f,
                       input logic b, input logic m);
    stage = s;
    {reg_write, mem_write, branch, jump, halt} = f;
    branch_taken = b;
    mem_ready = m;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // add: IF ID EX WB (EX row carries junk decoder inputs)
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b101, F_RW, 0, 1, P_ID));
    tbl.push_back(mk(3'b000, F_JP | F_HT, 1, 1, P_EX));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_WB | B_RF | B_DONE));
    // lw with two MEM stall cycles
    tbl.push_back(mk(3'b000, F_0,  0, 0, P_IF));
    tbl.push_back(mk(3'b111, F_RW, 0, 0, P_ID));
    tbl.push_back(mk(3'b000, F_0,  0, 0, P_EX));
    tbl.push_back(mk(3'b000, F_0,  0, 0, P_MEM));
    tbl.push_back(mk(3'b000, F_0,  0, 0, P_MEM));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_MEM));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_WB | B_RF | B_DONE));
    // sw with mem_ready 0,0,1
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b110, F_MW, 0, 1, P_ID));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_EX));
    tbl.push_back(mk(3'b000, F_0,  0, 0, P_MEM));
    tbl.push_back(mk(3'b000, F_0,  0, 0, P_MEM));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_MEM | B_DM | B_DONE));
    // beq taken, then not taken
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b100, F_BR, 0, 1, P_ID));
    tbl.push_back(mk(3'b000, F_0,  1, 1, P_EX | B_PCB | B_DONE));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b100, F_BR, 0, 1, P_ID));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_EX | B_DONE));
    // illegal stage 010 behaves as ID-last
    tbl.push_back(mk(3'b000, F_0,  1, 1, P_IF));
    tbl.push_back(mk(3'b010, F_0,  0, 1, P_ID | B_DONE));
    // j
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b000, F_JP, 0, 1, P_ID | B_PCJ | B_DONE));
    // addi (no reg write flag here) with branch_taken high in EX
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b101, F_0,  0, 1, P_ID));
    tbl.push_back(mk(3'b000, F_0,  1, 1, P_EX));
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_WB | B_DONE));
    // halt (with jump also set: no PC jump, no done)
    tbl.push_back(mk(3'b000, F_0,  0, 1, P_IF));
    tbl.push_back(mk(3'b000, F_HT | F_JP, 0, 1, P_ID));
    tbl.push_back(mk(3'b101, F_RW, 1, 1, B_HALT));

    apply(3'b000, F_0, 0, 1);
    rst = 1'b1;
    tick;
    chk("rst_main_phases", {19'd0, obs[11:8], obs[0]}, 32'd0);
    chk("rst_hold_outputs", {19'd0, obs_h}, 32'd0);
    tick;
`ifdef SEQ_PERF_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].stg, tbl[i].flg, tbl[i].bt, tbl[i].mr);
      #1;
      chk($sformatf("vec%0d", i), {19'd0, obs}, {19'd0, tbl[i].exp});
      if (i < 3) chk($sformatf("hold_if%0d", i), {31'd0, h_if}, {31'd0, (i == 2)});
      tick;
    end

    // HALT is absorbing regardless of inputs
`ifdef SEQ_PERF_CNT_EN
    h_cyc = cycle_cnt;
`endif
    for (int i = 0; i < 20; i++) begin
      apply(3'($urandom_range(7)), 5'($urandom_range(31)), 1'($urandom_range(1)),
            1'($urandom_range(1)));
      #1;
      chk($sformatf("halt%0d", i), {19'd0, obs}, {19'd0, B_HALT});
      tick;
    end
`ifdef SEQ_PERF_CNT_EN
    chk("halt_cycle_frozen", cycle_cnt, h_cyc);
`endif

    // one-cycle reset leaves HALT
    apply(3'b000, F_0, 0, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("post_halt_if", {19'd0, obs}, {19'd0, P_IF});

    // three adds back to back
    for (int k = 0; k < 3; k++) begin
      apply(3'b000, F_0, 0, 1); tick;
      apply(3'b101, F_RW, 0, 1); tick;
      apply(3'b000, F_0, 0, 1); #1;
      chk($sformatf("add%0d_ex", k), {19'd0, obs}, {19'd0, P_EX});
      tick;
      chk($sformatf("add%0d_wb", k), {19'd0, obs}, {19'd0, P_WB | B_RF | B_DONE});
      tick;
    end
    chk("add3_next_if", {19'd0, obs}, {19'd0, P_IF});
`ifdef SEQ_PERF_CNT_EN
    chk("cycle_cnt_3add", cycle_cnt, 32'd12);
    chk("retire_cnt_3add", retire_cnt, 32'd3);
`endif

    // reset wins over a stalled MEM
    tick;
    apply(3'b111, F_RW, 0, 0); tick;
    apply(3'b000, F_0, 0, 0); tick;
    chk("lw_stall_mem", {19'd0, obs}, {19'd0, P_MEM});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_over_mem", {19'd0, obs}, {19'd0, P_IF});
`ifdef SEQ_PERF_CNT_EN
    chk("rst_over_mem_cnt", cycle_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
